// File: rtl/fft_frame_tx.sv
// fft_frame_tx: ping-pong frame buffer driving the FFT streaming interface.
// The host fills one bank while the other bank is replayed as a burst.
module fft_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LDN    = 11,
  parameter int MIN_LDN    = 3,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_real_i,
  input  logic [DATA_WIDTH-1:0] wr_imag_i,
  input  logic [3:0]            ldn_i,
  input  logic                  bit_rev_i,
  output logic                  wr_rdy_o,
  output logic                  block_sync_o,
  output logic                  data_val_o,
  output logic [DATA_WIDTH-1:0] data_real_o,
  output logic [DATA_WIDTH-1:0] data_imag_o,
  output logic [3:0]            ldn_o,
  output logic [15:0]           frm_cnt_o
);

  localparam int AW = MAX_LDN;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int GW = 16;
  localparam logic [3:0] LDN_MIN = 4'(MIN_LDN);
  localparam logic [3:0] LDN_MAX = 4'(MAX_LDN);
  localparam logic [AW-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_st_t;

  function automatic logic [AW-1:0] last_idx(
    input logic [3:0] ldn
  );
    return ONES >> (LDN_MAX - ldn);
  endfunction

  // Reverse all AW bits, then drop the bits above ldn.
  function automatic logic [AW-1:0] bit_rev(
    input logic [AW-1:0] k,
    input logic [3:0]    ldn
  );
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = k[AW-1-i];
    end
    return r >> (LDN_MAX - ldn);
  endfunction

  logic [SW-1:0] mem [2**(AW+1)];
  logic [SW-1:0] rd_data;

  logic          fill_bank;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    bank_full;
  logic [3:0]    bank_ldn [2];
  logic [1:0]    bank_rev;
  logic [3:0]    ldn_clamp;
  logic [3:0]    wr_ldn;
  logic          wr_acc;
  logic          wr_last;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  tx_st_t        st_q;
  tx_st_t        st_d;
  logic          rd_bank;
  logic [AW-1:0] rd_k;
  logic [3:0]    tx_ldn;
  logic          tx_rev;
  logic [GW-1:0] gap_cnt;
  logic          rd_en;
  logic          rd_first;
  logic          rd_last;
  logic [AW-1:0] rd_addr;

  logic          vld1;
  logic          sync1;
  logic          last1;
  logic          last2;

  always_comb begin
    unique case (1'b1)
      (ldn_i < LDN_MIN): ldn_clamp = LDN_MIN;
      (ldn_i > LDN_MAX): ldn_clamp = LDN_MAX;
      default:           ldn_clamp = ldn_i;
    endcase
  end

  // The fill bank is only full when both banks are.
  assign wr_rdy_o = ~bank_full[fill_bank];
  assign wr_acc   = wr_en_i & wr_rdy_o;
  assign wr_ldn   = (wr_ptr == '0) ? ldn_clamp
                                   : bank_ldn[fill_bank];
  assign wr_last  = wr_acc
                  & (wr_ptr == last_idx(wr_ldn));

  assign full_set = wr_last ? (2'b01 << fill_bank)
                            : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rd_bank)
                            : 2'b00;

  always_ff @(posedge clk_sys) begin
    if (wr_acc) begin
      mem[{fill_bank, wr_ptr}] <= {wr_real_i, wr_imag_i};
    end
    if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      fill_bank   <= 1'b0;
      wr_ptr      <= '0;
      bank_ldn[0] <= LDN_MIN;
      bank_ldn[1] <= LDN_MIN;
      bank_rev    <= '0;
    end else if (wr_acc) begin
      if (wr_ptr == '0) begin
        bank_ldn[fill_bank] <= ldn_clamp;
        bank_rev[fill_bank] <= bit_rev_i;
      end
      if (wr_last) begin
        fill_bank <= ~fill_bank;
        wr_ptr    <= '0;
      end else begin
        wr_ptr    <= wr_ptr + 1'b1;
      end
    end
  end

  // Set and clear never target the same bank.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      bank_full <= '0;
    end else begin
      bank_full <= (bank_full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          st_d = SEND;
        end
      end
      SEND: begin
        if (rd_k == last_idx(tx_ldn)) begin
          st_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // IDLE issues sample 0; SEND issues samples 1..N-1.
  always_comb begin
    rd_en    = 1'b0;
    rd_first = 1'b0;
    rd_last  = 1'b0;
    rd_addr  = '0;
    unique case (st_q)
      IDLE: begin
        rd_en    = bank_full[rd_bank];
        rd_first = bank_full[rd_bank];
      end
      SEND: begin
        rd_en   = 1'b1;
        rd_last = (rd_k == last_idx(tx_ldn));
        rd_addr = tx_rev ? bit_rev(rd_k, tx_ldn)
                         : rd_k;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rd_bank <= 1'b0;
      rd_k    <= '0;
      tx_ldn  <= LDN_MIN;
      tx_rev  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (rd_first) begin
        rd_k   <= AW'(1);
        tx_ldn <= bank_ldn[rd_bank];
        tx_rev <= bank_rev[rd_bank];
      end else if (st_q == SEND) begin
        rd_k   <= rd_k + 1'b1;
      end
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
      if (st_q == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      vld1  <= 1'b0;
      sync1 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      vld1  <= rd_en;
      sync1 <= rd_first;
      last1 <= rd_last;
    end
  end

  // tx_ldn already holds the new frame's ldn when sync1 is high.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      data_val_o   <= 1'b0;
      block_sync_o <= 1'b0;
      data_real_o  <= '0;
      data_imag_o  <= '0;
      ldn_o        <= LDN_MIN;
      last2        <= 1'b0;
      frm_cnt_o    <= '0;
    end else begin
      data_val_o   <= vld1;
      block_sync_o <= sync1;
      data_real_o  <= vld1 ? rd_data[SW-1 -: DATA_WIDTH]
                           : '0;
      data_imag_o  <= vld1 ? rd_data[DATA_WIDTH-1:0]
                           : '0;
      if (sync1) begin
        ldn_o <= tx_ldn;
      end
      last2 <= vld1 & last1;
      if (last2) begin
        frm_cnt_o <= frm_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_tx.sv
// tb_fft_frame_tx: directed bench for fft_frame_tx.
// Two instances: back-to-back (GAP 0) and gapped (GAP 4).
`timescale 1ns/1ps
module tb_fft_frame_tx;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        wr_en;
  logic        wr_en2;
  logic [15:0] wr_real;
  logic [15:0] wr_imag;
  logic [3:0]  ldn;
  logic        bit_rev;

  logic        wr_rdy,     wr_rdy2;
  logic        block_sync, block_sync2;
  logic        data_val,   data_val2;
  logic [15:0] data_real,  data_real2;
  logic [15:0] data_imag,  data_imag2;
  logic [3:0]  ldn_o,      ldn_o2;
  logic [15:0] frm_cnt,    frm_cnt2;

  always #5 clk_sys = ~clk_sys;

  fft_frame_tx dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .wr_en_i      (wr_en),
    .wr_real_i    (wr_real),
    .wr_imag_i    (wr_imag),
    .ldn_i        (ldn),
    .bit_rev_i    (bit_rev),
    .wr_rdy_o     (wr_rdy),
    .block_sync_o (block_sync),
    .data_val_o   (data_val),
    .data_real_o  (data_real),
    .data_imag_o  (data_imag),
    .ldn_o        (ldn_o),
    .frm_cnt_o    (frm_cnt)
  );

  fft_frame_tx #(.GAP_CYCLES(4)) dut_gap (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .wr_en_i      (wr_en2),
    .wr_real_i    (wr_real),
    .wr_imag_i    (wr_imag),
    .ldn_i        (ldn),
    .bit_rev_i    (bit_rev),
    .wr_rdy_o     (wr_rdy2),
    .block_sync_o (block_sync2),
    .data_val_o   (data_val2),
    .data_real_o  (data_real2),
    .data_imag_o  (data_imag2),
    .ldn_o        (ldn_o2),
    .frm_cnt_o    (frm_cnt2)
  );

  typedef struct {
    int          cyc;
    logic        sync;
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  ldn;
    logic [15:0] frm;
  } smp_t;

  smp_t q0[$];
  smp_t q2[$];
  int   cyc = 0;
  int   rdy2_low = 0;
  int   last_wr = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (data_val === 1'b1)
      q0.push_back('{cyc, block_sync, data_real,
                     data_imag, ldn_o, frm_cnt});
    if (data_val2 === 1'b1)
      q2.push_back('{cyc, block_sync2, data_real2,
                     data_imag2, ldn_o2, frm_cnt2});
    if (wr_rdy2 !== 1'b1) rdy2_low++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    wr_en     = 1'b0;
    wr_en2    = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // Non-first writes carry junk ldn/bit_rev that must be ignored.
  task automatic wr_frame(input bit sel, input int n,
                          input logic [3:0] l,
                          input bit rev);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 8000) begin
      @(negedge clk_sys);
      guard++;
      if ((sel ? wr_rdy2 : wr_rdy) === 1'b1) begin
        wr_en   = ~sel;
        wr_en2  = sel;
        wr_real = 16'(k);
        wr_imag = 16'(-k);
        ldn     = (k == 0) ? l : 4'd7;
        bit_rev = (k == 0) ? rev : ~rev;
        last_wr = cyc;
        k++;
      end else begin
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
      end
    end
    if (k < n) chk("wr_timeout", k, n);
  endtask

  task automatic wr_stop();
    @(negedge clk_sys);
    wr_en  = 1'b0;
    wr_en2 = 1'b0;
  endtask

  task automatic wait_n(input bit sel, input int target,
                        input int budget);
    int t = 0;
    while ((sel ? q2.size() : q0.size()) < target
           && t < budget) begin
      @(negedge clk_sys);
      #1;
      t++;
    end
    chk(sel ? "wait_q2" : "wait_q0",
        32'((sel ? q2.size() : q0.size()) >= target),
        32'd1);
  endtask

  task automatic check_frame(input string tag,
                             input int base, input int n,
                             input logic [3:0] l);
    int   e_val = 0;
    int   e_sync = 0;
    int   e_gap = 0;
    int   e_ldn = 0;
    smp_t s;
    for (int i = 0; i < n; i++) begin
      s = q0[base+i];
      if (s.re !== 16'(i) || s.im !== 16'(-i)) e_val++;
      if (s.sync !== (i == 0)) e_sync++;
      if (s.cyc != q0[base].cyc + i) e_gap++;
      if (s.ldn !== l) e_ldn++;
    end
    chk({tag, "_data"}, e_val, 0);
    chk({tag, "_sync"}, e_sync, 0);
    chk({tag, "_holes"}, e_gap, 0);
    chk({tag, "_ldn"}, e_ldn, 0);
  endtask

  logic [15:0] rev8 [8];
  int base;
  int r0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    rev8 = '{16'd0, 16'd4, 16'd2, 16'd6,
             16'd1, 16'd5, 16'd3, 16'd7};
    rst_sys_n = 1'b0;
    wr_en     = 1'b0;
    wr_en2    = 1'b0;
    wr_real   = '0;
    wr_imag   = '0;
    ldn       = '0;
    bit_rev   = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rst_val", data_val, 0);
    chk("rst_sync", block_sync, 0);
    chk("rst_re", data_real, 0);
    chk("rst_im", data_imag, 0);
    chk("rst_ldn", ldn_o, 3);
    chk("rst_frm", frm_cnt, 0);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_rdy", wr_rdy, 1);

    // natural order, ldn 3
    do_reset();
    base = q0.size();
    wr_frame(0, 8, 4'd3, 1'b0);
    wr_stop();
    wait_n(0, base + 8, 50);
    check_frame("t1", base, 8, 4'd3);
    chk("t1_latency", q0[base].cyc - last_wr, 3);
    chk("t1_frm_at_last", q0[base+7].frm, 0);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("t1_frm", frm_cnt, 1);
    chk("t1_count", q0.size() - base, 8);
    chk("t1_idle_val", data_val, 0);

    // bit-reversed order, ldn 3
    do_reset();
    base = q0.size();
    wr_frame(0, 8, 4'd3, 1'b1);
    wr_stop();
    wait_n(0, base + 8, 50);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_re%0d", i),
          q0[base+i].re, rev8[i]);
      chk($sformatf("t2_im%0d", i),
          q0[base+i].im, 16'(-rev8[i]));
    end
    chk("t2_sync", q0[base].sync, 1);
    chk("t2_span", q0[base+7].cyc - q0[base].cyc, 7);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("t2_frm", frm_cnt, 1);

    // three back-to-back 16-sample frames
    do_reset();
    base = q0.size();
    wr_frame(0, 16, 4'd4, 1'b0);
    wr_frame(0, 16, 4'd4, 1'b0);
    wr_frame(0, 16, 4'd4, 1'b0);
    wr_stop();
    wait_n(0, base + 48, 200);
    check_frame("t3_f0", base, 16, 4'd4);
    check_frame("t3_f1", base + 16, 16, 4'd4);
    check_frame("t3_f2", base + 32, 16, 4'd4);
    chk("t3_burst", q0[base+47].cyc - q0[base].cyc, 47);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("t3_count", q0.size() - base, 48);
    chk("t3_frm", frm_cnt, 3);

    // clamping: ldn 2 -> 8 samples, ldn 12 -> 2048
    do_reset();
    base = q0.size();
    wr_frame(0, 8, 4'd2, 1'b0);
    wr_frame(0, 2048, 4'd12, 1'b0);
    wr_stop();
    wait_n(0, base + 2056, 4500);
    check_frame("t4_small", base, 8, 4'd3);
    check_frame("t4_big", base + 8, 2048, 4'd11);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("t4_count", q0.size() - base, 2056);
    chk("t4_frm", frm_cnt, 2);

    // async reset at sample 5 of a 64-sample frame
    base = q0.size();
    wr_frame(0, 64, 4'd6, 1'b0);
    wr_stop();
    wait_n(0, base + 6, 100);
    chk("t5_pre_re", data_real, 5);
    chk("t5_pre_frm", frm_cnt, 2);
    rst_sys_n = 1'b0;
    #1;
    chk("t5_val", data_val, 0);
    chk("t5_sync", block_sync, 0);
    chk("t5_re", data_real, 0);
    chk("t5_im", data_imag, 0);
    chk("t5_frm", frm_cnt, 0);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    base = q0.size();
    repeat (100) @(negedge clk_sys);
    #1;
    chk("t5_resid", q0.size() - base, 0);
    chk("t5_rdy", wr_rdy, 1);
    chk("t5_frm_post", frm_cnt, 0);

    // gapped instance: three ldn 3 frames
    do_reset();
    base = q2.size();
    r0 = rdy2_low;
    wr_frame(1, 8, 4'd3, 1'b0);
    wr_frame(1, 8, 4'd3, 1'b0);
    wr_frame(1, 8, 4'd3, 1'b0);
    wr_stop();
    wait_n(1, base + 24, 200);
    chk("t6_gap1",
        q2[base+8].cyc - q2[base+7].cyc - 1, 4);
    chk("t6_gap2",
        q2[base+16].cyc - q2[base+15].cyc - 1, 4);
    chk("t6_sync1", q2[base+8].sync, 1);
    chk("t6_re7", q2[base+7].re, 7);
    chk("t6_re8", q2[base+8].re, 0);
    chk("t6_span", q2[base+7].cyc - q2[base].cyc, 7);
    repeat (3) @(negedge clk_sys);
    #1;
    chk("t6_rdy_low", rdy2_low - r0, 4);
    chk("t6_frm", frm_cnt2, 3);
    chk("t6_count", q2.size() - base, 24);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
